// File: rtl/match_bind_pkg.sv
// rtl/match_bind_pkg.sv - tag encodings and the push-side word transform
package match_bind_pkg;

   typedef enum logic [1:0] {
      TAG_HIT  = 2'h0,
      TAG_MISS = 2'h1,
      TAG_IDLE = 2'h2
   } tag_e;

   localparam int unsigned MAX_W = 64;

   // Works on a zero-extended word; callers truncate the result back to their width.
   function automatic logic [MAX_W-1:0] bind_transform(
      input logic [MAX_W-1:0] word,
      input logic             hit,
      input logic             mode,
      input int unsigned      width
   );
      logic [MAX_W-1:0] mask;
      mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      if (hit) begin
         return word & mask;
      end else if (!mode) begin
         return ~word & mask;
      end else begin
         return ((word << 1) | (word >> (width - 1))) & mask;
      end
   endfunction

endpackage

// File: rtl/match_bind_stream_if.sv
// rtl/match_bind_stream_if.sv - valid/ready word stream bundle
interface match_bind_stream_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/match_bind_fifo.sv
// rtl/match_bind_fifo.sv - wrapping-pointer FIFO; head reads as zero when empty
module match_bind_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   match_bind_stream_if.slave         wr,
   match_bind_stream_if.master        rd,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr = '0;
   logic [PW-1:0]    rd_ptr = '0;
   logic [CW-1:0]    occ    = '0;
   logic             push;
   logic             pop;

   assign wr.tready = (occ < CW'(DEPTH));
   assign rd.tvalid = (occ != '0);
   // Storage is never cleared, so the head is masked to keep stale words hidden.
   assign rd.tdata  = rd.tvalid ? mem[rd_ptr] : '0;
   assign push      = wr.tvalid && wr.tready;
   assign pop       = rd.tvalid && rd.tready;
   assign count     = occ;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr.tdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end
endmodule

// File: rtl/match_bind_stream.sv
// rtl/match_bind_stream.sv - bit-test transform in front of a FIFO, with last-pop tag
module match_bind_stream
   import match_bind_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned SEL_BIT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        __in0,
   input  logic                    __in0_valid,
   output logic                    __in0_ready,
   input  logic                    __mode,
   output logic [WIDTH-1:0]        __out0,
   output logic                    __out0_valid,
   input  logic                    __out0_ready,
   output logic [1:0]              __tag,
   output logic [$clog2(DEPTH):0]  __count
);
   match_bind_stream_if #(.W(WIDTH + 1)) wr_s ();
   match_bind_stream_if #(.W(WIDTH + 1)) rd_s ();

   logic             hit;
   logic [WIDTH-1:0] stored_word;
   tag_e             tag_q = TAG_IDLE;

   assign hit         = ~__in0[SEL_BIT];
   assign stored_word = WIDTH'(bind_transform(MAX_W'(__in0), hit, __mode, WIDTH));

   // The hit bit rides in the top bit of each entry so the tag follows the popped word.
   assign wr_s.tdata  = {hit, stored_word};
   assign wr_s.tvalid = __in0_valid;
   assign __in0_ready = wr_s.tready;

   assign __out0       = rd_s.tdata[WIDTH-1:0];
   assign __out0_valid = rd_s.tvalid;
   assign rd_s.tready  = __out0_ready;

   match_bind_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_s),
      .rd    (rd_s),
      .count (__count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q <= TAG_IDLE;
      end else if (rd_s.tvalid && rd_s.tready) begin
         tag_q <= rd_s.tdata[WIDTH] ? TAG_HIT : TAG_MISS;
      end
   end

   assign __tag = tag_q;
endmodule

// File: tb/tb_match_bind_stream.sv
// tb/tb_match_bind_stream.sv - directed-vector bench for match_bind_stream
module tb_match_bind_stream;
   logic       clk;
   logic       rst;
   logic       __mode;
   logic [7:0] __out0;
   logic       __out0_valid;
   logic       __out0_ready;
   logic [1:0] __tag;
   logic [2:0] __count;
   int         vectors;
   int         miscompares;

   match_bind_stream_if #(.W(8)) tb_in ();

   match_bind_stream #(.WIDTH(8), .DEPTH(4), .SEL_BIT(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .__in0        (tb_in.tdata),
      .__in0_valid  (tb_in.tvalid),
      .__in0_ready  (tb_in.tready),
      .__mode       (__mode),
      .__out0       (__out0),
      .__out0_valid (__out0_valid),
      .__out0_ready (__out0_ready),
      .__tag        (__tag),
      .__count      (__count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; tb_in.tdata = 8'h00; tb_in.tvalid = 1'b0; __mode = 1'b0; __out0_ready = 1'b0;
      tick(); tick();
      vectors++; if (__out0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", __out0_valid); end
      vectors++; if (tb_in.tready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", tb_in.tready); end
      vectors++; if (__tag !== 2'h2) begin miscompares++; $display("FAIL reset_tag: got %h want 2", __tag); end
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", __count); end
      vectors++; if (__out0 !== 8'h00) begin miscompares++; $display("FAIL reset_out: got %h want 00", __out0); end
   endtask

   task automatic test_hit_pass();
      rst = 1'b1;
      tb_in.tdata = 8'h04; tb_in.tvalid = 1'b1; __mode = 1'b0; __out0_ready = 1'b0;
      tick();
      tb_in.tvalid = 1'b0;
      vectors++; if (__out0 !== 8'h04) begin miscompares++; $display("FAIL hit_out: got %h want 04", __out0); end
      vectors++; if (__out0_valid !== 1'b1) begin miscompares++; $display("FAIL hit_valid: got %b want 1", __out0_valid); end
      vectors++; if (__count !== 3'd1) begin miscompares++; $display("FAIL hit_count: got %0d want 1", __count); end
      __out0_ready = 1'b1;
      tick();
      __out0_ready = 1'b0;
      vectors++; if (__tag !== 2'h0) begin miscompares++; $display("FAIL hit_tag: got %h want 0", __tag); end
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL hit_count_pop: got %0d want 0", __count); end
      vectors++; if (__out0 !== 8'h00) begin miscompares++; $display("FAIL hit_out_empty: got %h want 00", __out0); end
   endtask

   task automatic test_miss_modes();
      tb_in.tdata = 8'h05; tb_in.tvalid = 1'b1; __mode = 1'b0;
      tick();
      tb_in.tdata = 8'h81; __mode = 1'b1;
      tick();
      tb_in.tvalid = 1'b0; __mode = 1'b0;
      vectors++; if (__count !== 3'd2) begin miscompares++; $display("FAIL miss_count: got %0d want 2", __count); end
      vectors++; if (__out0 !== 8'hFA) begin miscompares++; $display("FAIL miss_invert: got %h want fa", __out0); end
      __out0_ready = 1'b1;
      tick();
      vectors++; if (__tag !== 2'h1) begin miscompares++; $display("FAIL miss_tag1: got %h want 1", __tag); end
      vectors++; if (__out0 !== 8'h03) begin miscompares++; $display("FAIL miss_rotate: got %h want 03", __out0); end
      tick();
      __out0_ready = 1'b0;
      vectors++; if (__tag !== 2'h1) begin miscompares++; $display("FAIL miss_tag2: got %h want 1", __tag); end
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL miss_drain: got %0d want 0", __count); end
   endtask

   task automatic test_full();
      logic [7:0] vals [0:3];
      vals = '{8'h10, 8'h20, 8'h30, 8'h40};
      tb_in.tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tb_in.tdata = vals[i];
         tick();
      end
      vectors++; if (__count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", __count); end
      vectors++; if (tb_in.tready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", tb_in.tready); end
      tb_in.tdata = 8'h50;
      tick();
      tb_in.tvalid = 1'b0;
      vectors++; if (__count !== 3'd4) begin miscompares++; $display("FAIL full_drop_count: got %0d want 4", __count); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (__out0 !== vals[i]) begin miscompares++; $display("FAIL full_order[%0d]: got %h want %h", i, __out0, vals[i]); end
         __out0_ready = 1'b1;
         tick();
         __out0_ready = 1'b0;
      end
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL full_drain: got %0d want 0", __count); end
      vectors++; if (__out0_valid !== 1'b0) begin miscompares++; $display("FAIL full_empty_valid: got %b want 0", __out0_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [0:7];
      seq = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h12};
      tb_in.tvalid = 1'b1;
      tb_in.tdata = seq[0]; tick();
      tb_in.tdata = seq[1]; tick();
      __out0_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tb_in.tdata = seq[k + 2];
         vectors++; if (__out0 !== seq[k]) begin miscompares++; $display("FAIL b2b_head[%0d]: got %h want %h", k, __out0, seq[k]); end
         tick();
         vectors++; if (__count !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, __count); end
      end
      tb_in.tvalid = 1'b0;
      for (int k = 6; k < 8; k++) begin
         vectors++; if (__out0 !== seq[k]) begin miscompares++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, __out0, seq[k]); end
         tick();
      end
      __out0_ready = 1'b0;
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL b2b_final: got %0d want 0", __count); end
   endtask

   task automatic test_reset_flush();
      tb_in.tvalid = 1'b1;
      tb_in.tdata = 8'h20; tick();
      tb_in.tdata = 8'h40; tick();
      tb_in.tdata = 8'h60; tick();
      vectors++; if (__count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count: got %0d want 3", __count); end
      rst = 1'b0; tb_in.tdata = 8'h80; __out0_ready = 1'b1;
      tick();
      rst = 1'b1; tb_in.tvalid = 1'b0; __out0_ready = 1'b0;
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", __count); end
      vectors++; if (__tag !== 2'h2) begin miscompares++; $display("FAIL flush_tag: got %h want 2", __tag); end
      vectors++; if (__out0_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", __out0_valid); end
      vectors++; if (__out0 !== 8'h00) begin miscompares++; $display("FAIL flush_out: got %h want 00", __out0); end
      tb_in.tdata = 8'h02; tb_in.tvalid = 1'b1;
      tick();
      tb_in.tvalid = 1'b0;
      vectors++; if (__out0 !== 8'h02) begin miscompares++; $display("FAIL flush_push_out: got %h want 02", __out0); end
      vectors++; if (__count !== 3'd1) begin miscompares++; $display("FAIL flush_push_count: got %0d want 1", __count); end
      __out0_ready = 1'b1;
      tick();
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL flush_pop_count: got %0d want 0", __count); end
      tick();
      __out0_ready = 1'b0;
      vectors++; if (__count !== 3'd0) begin miscompares++; $display("FAIL empty_pop_count: got %0d want 0", __count); end
      vectors++; if (__tag !== 2'h0) begin miscompares++; $display("FAIL empty_pop_tag: got %h want 0", __tag); end
      vectors++; if (__out0_valid !== 1'b0) begin miscompares++; $display("FAIL empty_pop_valid: got %b want 0", __out0_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_hit_pass();
      test_miss_modes();
      test_full();
      test_back_to_back();
      test_reset_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/match_bind_stream.md
MATCH_BIND_STREAM -- requirements
Module: match_bind_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 2.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries, power of two, minimum 2.
REQ-003 SHALL have parameter SEL_BIT, default 0: index of the tested bit, range 0..WIDTH-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port __in0, input, WIDTH bits: input data word.
REQ-007 SHALL have port __in0_valid, input, 1 bit: the producer offers __in0.
REQ-008 SHALL have port __in0_ready, output, 1 bit: the block can accept a word.
REQ-009 SHALL have port __mode, input, 1 bit: transform select, sampled with each accepted word.
REQ-010 SHALL have port __out0, output, WIDTH bits: transformed word at the buffer head.
REQ-011 SHALL have port __out0_valid, output, 1 bit: __out0 holds a valid word.
REQ-012 SHALL have port __out0_ready, input, 1 bit: the consumer accepts __out0.
REQ-013 SHALL have port __tag, output, 2 bits: branch taken by the last popped word.
REQ-014 SHALL have port __count, output, $clog2(DEPTH)+1 bits: buffer occupancy.

Function
REQ-015 Push SHALL occur on a clock edge when __in0_valid and __in0_ready are both 1; pop SHALL occur on a clock edge when __out0_valid and __out0_ready are both 1.
REQ-016 At push, hit SHALL equal (__in0[SEL_BIT] == 0).
REQ-017 At push, the stored word SHALL be:
- __in0 when hit is 1;
- the bitwise inverse of __in0 when hit is 0 and __mode is 0;
- __in0 rotated left by 1 when hit is 0 and __mode is 1.
The hit bit SHALL be stored with the word.
REQ-018 The buffer SHALL be FIFO-ordered, with read and write pointers that wrap modulo DEPTH.
REQ-019 Latency SHALL be one cycle: a word pushed at edge t appears on __out0 after edge t. There is no combinational path from __in0 to __out0.
REQ-020 __in0_ready SHALL be (__count < DEPTH), registered-state derived; there is no pass-through when the buffer is full.
REQ-021 __out0_valid SHALL be (__count != 0); __out0 SHALL be all zeros whenever __out0_valid is 0.
REQ-022 Simultaneous push and pop SHALL leave __count unchanged and advance both pointers.
REQ-023 A push attempted while full SHALL be ignored; state and data SHALL be unchanged.
REQ-024 __out0_ready asserted while empty SHALL have no effect.
REQ-025 The __tag state machine SHALL have three states and change only on a pop:
- TAG_IDLE = 2'h2: no pop since reset;
- TAG_HIT = 2'h0: the popped word had hit = 1;
- TAG_MISS = 2'h1: the popped word had hit = 0.
Transitions between any states SHALL depend only on the popped hit bit; 2'h3 SHALL be unreachable.
REQ-026 __count SHALL increment on push-only, decrement on pop-only, and never leave the range 0..DEPTH.

Reset
REQ-027 When rst == 0 at a rising clk edge, the block SHALL set:
- __count = 0;
- both pointers = 0;
- __tag = 2'h2.
REQ-028 Reset values SHALL be: __out0 = 0, __out0_valid = 0, __in0_ready = 1, __tag = 2'h2, __count = 0.
REQ-029 Buffer storage SHALL not be cleared by reset; stale contents SHALL never be visible at the outputs.
REQ-030 Reset SHALL take priority over a simultaneous push or pop; words in flight SHALL be discarded.
REQ-031 Initial (pre-reset) register state SHALL equal the reset state.

Structure
REQ-032 Package match_bind_pkg SHALL hold:
- the tag constants TAG_HIT, TAG_MISS and TAG_IDLE;
- the transform function (word, hit, mode to stored word).
REQ-033 Storage and pointers SHALL live in one sub-module, match_bind_fifo (parameters WIDTH+1 and DEPTH). The top SHALL hold the transform, the tag state machine and the handshakes.

Verification (WIDTH=8, DEPTH=4, SEL_BIT=0)
REQ-034 Hold rst=0 for 2 cycles -> __out0_valid=0, __in0_ready=1, __tag=2'h2, __count=0, __out0=8'h00.
REQ-035 Push 8'h04 with __mode=0, __out0_ready=0 -> next cycle __out0=8'h04 and valid=1; then pop -> __tag=2'h0 and __count=0.
REQ-036 Push 8'h05 (mode 0) then 8'h81 (mode 1) -> outputs 8'hFA then 8'h03, in order; __tag=2'h1 after each pop.
REQ-037 Push 8'h10, 8'h20, 8'h30, 8'h40, 8'h50 with no pops -> __in0_ready=0 at __count=4; 8'h50 is dropped; pops return 10/20/30/40 in order.
REQ-038 Hold simultaneous push and pop at __count=2 for 6 cycles -> __count stays 2; order is preserved across pointer wrap.
REQ-039 Assert rst=0 with __count=3 and push active -> next cycle __count=0, __tag=2'h2, __out0_valid=0; a subsequent push of 8'h02 appears alone.
